// File: rtl/rr_drive_arbiter.sv
// rtl/rr_drive_arbiter.sv - packet-level round-robin arbiter onto one shared drive net with a two-slot output buffer
module rr_drive_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  output logic [ID_W-1:0]           out_src,
  input  logic                      out_ready,
  output logic                      busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;

  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic [ID_W-1:0]     out_src_q, out_src_d;

  logic                skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic                skid_last_q, skid_last_d;
  logic [ID_W-1:0]     skid_src_q, skid_src_d;

  logic [2*NUM_REQ-1:0] valid_rot;
  logic                 grant_found;
  logic [ID_W-1:0]      grant_id;
  logic                 sel_en;
  logic [ID_W-1:0]      sel_id;
  logic                 can_accept;
  logic                 accept;
  logic                 drain;
  logic [DATA_W-1:0]    acc_data;
  logic                 acc_last;
  int                   sum;

  // Rotating priority search: first valid requester at or after ptr, wrapping.
  always_comb begin
    valid_rot   = {req_valid, req_valid} >> ptr_q;
    grant_found = 1'b0;
    grant_id    = '0;
    sum         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && valid_rot[i]) begin
        grant_found = 1'b1;
        sum         = int'(ptr_q) + i;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        grant_id    = ID_W'(sum);
      end
    end
  end

  // Select the single requester allowed to push this cycle and mux its beat.
  always_comb begin
    sel_en     = (state_q == LOCKED) ? 1'b1 : grant_found;
    sel_id     = (state_q == LOCKED) ? owner_q : grant_id;
    can_accept = !skid_valid_q;
    req_ready  = '0;
    acc_data   = '0;
    acc_last   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_id == ID_W'(i)) begin
        req_ready[i] = !rst && sel_en && can_accept;
        acc_data     = req_data[i*DATA_W +: DATA_W];
        acc_last     = req_last[i];
      end
    end
    accept = |(req_valid & req_ready);
    drain  = out_valid_q && out_ready;
  end

  // Ownership FSM: lock on a non-last beat, release and advance ptr on last.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (accept) begin
      if (acc_last) begin
        state_d = IDLE;
        ptr_d   = (sel_id == ID_W'(NUM_REQ - 1)) ? '0 : sel_id + 1'b1;
      end else begin
        state_d = LOCKED;
        owner_d = sel_id;
      end
    end
  end

  // Two-slot buffer: OUT is the visible register, SKID absorbs one beat of backpressure.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_src_d    = out_src_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    skid_src_d   = skid_src_q;
    if (drain && skid_valid_q) begin
      out_valid_d  = 1'b1;
      out_data_d   = skid_data_q;
      out_last_d   = skid_last_q;
      out_src_d    = skid_src_q;
      skid_valid_d = 1'b0;
    end else if (drain || !out_valid_q) begin
      out_valid_d = accept;
      if (accept) begin
        out_data_d = acc_data;
        out_last_d = acc_last;
        out_src_d  = sel_id;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = acc_data;
      skid_last_d  = acc_last;
      skid_src_d   = sel_id;
    end
  end

  // State registers with synchronous reset; in-flight beats are dropped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      ptr_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_src_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      skid_src_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      ptr_q        <= ptr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_src_q    <= out_src_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      skid_src_q   <= skid_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;
  assign busy      = (state_q == LOCKED) || out_valid_q || skid_valid_q;

endmodule

// File: tb/tb_rr_drive_arbiter.sv
// tb/tb_rr_drive_arbiter.sv - randomized self-checking bench for rr_drive_arbiter
module tb_rr_drive_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int ID_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_last;
  logic [ID_W-1:0]           out_src;
  logic                      out_ready;
  logic                      busy;

  rr_drive_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: in-flight beats as a queue of {src, last, data}, at most two deep.
  logic [10:0]        mq[$];
  bit                 m_locked;
  int                 m_owner;
  int                 m_ptr;
  int                 rem[NUM_REQ];
  logic [7:0]         cur[NUM_REQ];
  logic [NUM_REQ-1:0] exp_ready;

  // Per phase: max packet length, new-packet %, valid %, out_ready %.
  int ph_len[4] = '{1, 4, 6, 3};
  int ph_gen[4] = '{100, 40, 60, 30};
  int ph_vld[4] = '{100, 75, 90, 50};
  int ph_rdy[4] = '{100, 60, 20, 95};

  initial begin
    int g;
    m_locked = 0;
    m_owner  = 0;
    m_ptr    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rem[i] = 0;
      cur[i] = 8'($urandom);
    end
    rst       = 1'b1;
    req_valid = '1;
    req_last  = '0;
    req_data  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_out_src",   32'(out_src),   32'd0);
    check("rst_busy",      32'(busy),      32'd0);

    for (int p = 0; p < 4; p++) begin
      for (int cyc = 0; cyc < 1500; cyc++) begin
        @(negedge clk);
        rst = (p > 0) && ($urandom_range(0, 299) == 0);
        for (int i = 0; i < NUM_REQ; i++) begin
          if (rem[i] == 0 && $urandom_range(0, 99) < ph_gen[p])
            rem[i] = $urandom_range(1, ph_len[p]);
          req_valid[i] = (rem[i] > 0) && ($urandom_range(0, 99) < ph_vld[p]);
          if (req_valid[i]) begin
            req_data[i*DATA_W +: DATA_W] = cur[i];
            req_last[i] = (rem[i] == 1);
          end else begin
            req_data[i*DATA_W +: DATA_W] = 8'($urandom);
            req_last[i] = 1'($urandom);
          end
        end
        out_ready = ($urandom_range(0, 99) < ph_rdy[p]);
        #1;

        exp_ready = '0;
        if (!rst && mq.size() < 2) begin
          if (m_locked) exp_ready[m_owner] = 1'b1;
          else begin
            for (int k = 0; k < NUM_REQ; k++) begin
              if (req_valid[(m_ptr + k) % NUM_REQ]) begin
                exp_ready[(m_ptr + k) % NUM_REQ] = 1'b1;
                break;
              end
            end
          end
        end
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        check("busy",      32'(busy),      32'(m_locked || mq.size() > 0));
        if (mq.size() > 0) begin
          check("out_data", 32'(out_data), 32'(mq[0][7:0]));
          check("out_last", 32'(out_last), 32'(mq[0][8]));
          check("out_src",  32'(out_src),  32'(mq[0][10:9]));
        end

        if (rst) begin
          mq.delete();
          m_locked = 0;
          m_ptr    = 0;
        end else begin
          if (mq.size() > 0 && out_ready) void'(mq.pop_front());
          g = -1;
          for (int i = 0; i < NUM_REQ; i++)
            if (req_valid[i] && exp_ready[i]) g = i;
          if (g >= 0) begin
            mq.push_back({2'(g), req_last[g], cur[g]});
            if (req_last[g]) begin
              m_locked = 0;
              m_ptr    = (g + 1) % NUM_REQ;
            end else begin
              m_locked = 1;
              m_owner  = g;
            end
            rem[g] = rem[g] - 1;
            cur[g] = 8'($urandom);
          end
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rr_drive_arbiter.md
# rr_drive_arbiter

Packet-level round-robin arbiter that shares one broadcast drive net among `NUM_REQ` upstream requesters. It feeds a downstream load group through a two-entry registered buffer stage (output register plus skid register). The block sits between the per-hierarchy requesters and the shared net. It guarantees one owner per packet, fair rotation, and full throughput under backpressure.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, must be ≥ 2.
- `DATA_W`, default 8: payload width per beat.
- `ID_W` is derived as ceil(log2(`NUM_REQ`)). It is not overridable.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: reset. Synchronous and active-high.
- `req_valid`, in, `NUM_REQ`: beat valid, one bit per requester.
- `req_last`, in, `NUM_REQ`: final beat of the packet, one bit per requester.
- `req_data`, in, `NUM_REQ*DATA_W`: payloads. Requester i occupies bits [i*DATA_W +: DATA_W].
- `req_ready`, out, `NUM_REQ`: per-requester accept. A beat transfers when `req_valid[i] & req_ready[i]`.
- `out_valid`, out, 1: beat available on the shared net.
- `out_data`, out, `DATA_W`: beat payload.
- `out_last`, out, 1: final beat of the packet.
- `out_src`, out, `ID_W`: index of the requester that produced the beat.
- `out_ready`, in, 1: downstream accept. A beat transfers when `out_valid & out_ready`.
- `busy`, out, 1: high when the state is LOCKED or either buffer slot is occupied.

## Operation
- State: FSM {IDLE, LOCKED}, `owner` (`ID_W` bits), `ptr` (`ID_W` bits), and two buffer slots, OUT and SKID, each holding {data, last, src, valid}.
- `can_accept` = SKID slot empty.
- IDLE grant:
  - The winner is the first i with `req_valid[i]` set, scanning i = `ptr`, `ptr`+1, … with mod-`NUM_REQ` wrap.
  - `req_ready[winner]` = `can_accept`. All other `req_ready` bits are 0.
  - The grant is combinational from `req_valid`, so a beat can be accepted in the same cycle it is requested.
- IDLE, accepted beat with `last`=0: go to LOCKED and set `owner` = winner.
- IDLE, accepted beat with `last`=1 (single-beat packet): stay in IDLE and set `ptr` = winner+1 mod `NUM_REQ`.
- LOCKED:
  - `req_ready[owner]` = `can_accept`. All other requesters get 0.
  - If the owner deasserts `req_valid` mid-packet, the block stays LOCKED and grants nobody else.
  - Accepted beat with `last`=1: go to IDLE and set `ptr` = `owner`+1 mod `NUM_REQ`. The wrap from `NUM_REQ`-1 goes to 0.
- Buffer rules:
  - An accepted beat fills OUT if OUT is empty or OUT is draining this cycle. Otherwise it fills SKID.
  - When OUT drains and SKID is full, SKID moves to OUT.
  - Beat order is strictly preserved.
- Simultaneous upstream accept and downstream drain in the same cycle is legal. It sustains 1 beat/cycle.
- `rst` mid-packet: buffered beats are discarded, FSM goes to IDLE, `ptr` = 0. Partial packets are not completed.
- The grant decision ignores `req_last` and `req_data` of non-winning requesters.

## Timing
- Reset values (the cycle after `rst` is sampled high):
  - `out_valid` = 0, `out_data` = 0, `out_last` = 0, `out_src` = 0.
  - `busy` = 0, `ptr` = 0, state = IDLE, both slots empty.
  - While `rst` is high, `req_ready` = 0.
- Latency: a beat accepted at edge t appears on `out_*` after edge t, i.e. one-cycle latency with empty buffers.
- Throughput:
  - 1 beat/cycle while `out_ready` = 1.
  - After `out_ready` falls, at most two further beats are accepted before all `req_ready` go low.
  - Accepts resume the cycle after SKID empties.
- `out_*` are driven only from registers. `req_ready` is combinational from `req_valid`, state, and slot occupancy. There is no combinational path from `out_ready` to `req_ready`.
- Packet switch: a new owner's first beat can be accepted in the cycle immediately after the previous owner's last beat is accepted. There are no bubble cycles.

## Test plan
- Single-beat rotation: `NUM_REQ`=4, all `req_valid`=1, all `req_last`=1, `out_ready`=1, 8 cycles. `out_src` must read 0,1,2,3,0,1,2,3 with `out_valid` continuously high from cycle 1.
- Packet lock: req0 sends 3 beats (0xA1, 0xA2, 0xA3 with last) while req1 is valid throughout. Output must be A1, A2, A3 (src 0), then req1's beat. `req_ready[1]` must stay 0 until A3 is accepted.
- Backpressure: stream from req2 with `out_ready`=0 for 5 cycles. Exactly 2 beats are accepted, then `req_ready`=0. On `out_ready`=1, the beats drain in order with no loss or duplication, and accepts resume.
- Owner stall: req3 sends a non-last beat, then drops valid for 4 cycles while req0 is valid. req0 must not be granted. req3's last beat completes the packet, then req0 is granted. `busy` stays 1 throughout.
- Reset mid-packet: assert `rst` with both slots full and state LOCKED. Next cycle: `out_valid`=0, `busy`=0. A new request from req1 is granted first among requesters 1–3 because `ptr`=0 and req0 is idle.
